// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: extracts and extends the instruction immediate (I/S/B/J/U, CSR zimm,
// shift amount) to XLEN bits, then holds it behind a valid/ready interface with a
// two-entry skid buffer so that in_ready never depends combinationally on out_ready.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [24:0]      in_imm,
    input  logic [2:0]       in_src,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    localparam logic [2:0] SRC_I     = 3'd0;
    localparam logic [2:0] SRC_S     = 3'd1;
    localparam logic [2:0] SRC_B     = 3'd2;
    localparam logic [2:0] SRC_J     = 3'd3;
    localparam logic [2:0] SRC_U     = 3'd4;
    localparam logic [2:0] SRC_ZIMM  = 3'd5;
    localparam logic [2:0] SRC_SHAMT = 3'd6;

    // ins is indexed with the original instruction bit numbers to keep the
    // format table readable; bits [6:0] never carry immediate data.
    function automatic logic [XLEN-1:0] ext_imm(input logic [31:7] ins, input logic [2:0] src);
        logic signed [XLEN-1:0] w;
        logic signed [31:0]     u;
        u = signed'({ins[31:12], 12'b0});
        case (src)
            SRC_I:     w = {{(XLEN-12){ins[31]}}, ins[31:20]};
            SRC_S:     w = {{(XLEN-12){ins[31]}}, ins[31:25], ins[11:7]};
            SRC_B:     w = {{(XLEN-12){ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
            SRC_J:     w = {{(XLEN-20){ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
            SRC_U:     w = XLEN'(u);
            SRC_ZIMM:  w = {{(XLEN-5){1'b0}}, ins[19:15]};
            SRC_SHAMT: w = (XLEN == 64) ? {{(XLEN-6){1'b0}}, ins[25:20]}
                                        : {{(XLEN-5){1'b0}}, ins[24:20]};
            default:   w = '0;
        endcase
        return w;
    endfunction

    logic [XLEN-1:0]  imm_p0;
    logic             ill_p0;
    logic             main_v, skid_v;
    logic [XLEN-1:0]  main_imm, skid_imm;
    logic [TAG_W-1:0] main_tag, skid_tag;
    logic             main_ill, skid_ill;
    logic             accept, pop;

    // Stage p0: combinational extension of the incoming entry
    assign imm_p0 = ext_imm(in_imm, in_src);
    assign ill_p0 = (in_src == 3'b111);

    assign in_ready    = !skid_v;
    assign accept      = in_valid && in_ready;
    assign pop         = main_v && out_ready;
    assign out_valid   = main_v;
    assign out_imm     = main_imm;
    assign out_tag     = main_tag;
    assign out_illegal = main_ill;

    // Stage p1: main/skid storage; skid drains into main before new entries
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_v   <= 1'b0;
            skid_v   <= 1'b0;
            main_imm <= '0;
            main_tag <= '0;
            main_ill <= 1'b0;
            skid_imm <= '0;
            skid_tag <= '0;
            skid_ill <= 1'b0;
        end else if (flush) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (!main_v || pop) begin
            if (skid_v) begin
                main_imm <= skid_imm;
                main_tag <= skid_tag;
                main_ill <= skid_ill;
                main_v   <= 1'b1;
                skid_v   <= 1'b0;
            end else if (accept) begin
                main_imm <= imm_p0;
                main_tag <= in_tag;
                main_ill <= ill_p0;
                main_v   <= 1'b1;
            end else begin
                main_v <= 1'b0;
            end
        end else if (accept) begin
            skid_imm <= imm_p0;
            skid_tag <= in_tag;
            skid_ill <= ill_p0;
            skid_v   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances driven in lockstep, with a
// queue-based scoreboard fed from an arithmetic reference model of the formats.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [24:0] in_imm = '0;
    logic [2:0]  in_src = '0;
    logic [31:0] in_tag = '0;
    logic        out_ready = 1'b1;

    logic        in_ready32, in_ready64, out_valid32, out_valid64, out_ill32, out_ill64;
    logic [31:0] out_imm32, out_tag32, out_tag64;
    logic [63:0] out_imm64;

    int checks = 0;
    int errors = 0;
    bit seen_stall = 0;

    typedef struct {
        logic [63:0] i32;
        logic [63:0] i64;
        logic [31:0] tag;
        logic        ill;
    } exp_t;
    exp_t exp_q[$];

    imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
        .in_imm(in_imm), .in_src(in_src), .in_tag(in_tag), .out_valid(out_valid32),
        .out_ready(out_ready), .out_imm(out_imm32), .out_tag(out_tag32), .out_illegal(out_ill32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .in_imm(in_imm), .in_src(in_src), .in_tag(in_tag), .out_valid(out_valid64),
        .out_ready(out_ready), .out_imm(out_imm64), .out_tag(out_tag64), .out_illegal(out_ill64)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    // Reference: numeric value of each format, then reduced modulo 2^xlen.
    function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] src, input int xlen);
        longint v;
        case (src)
            3'd0: begin v = longint'(ins[31:20]); if (v >= 2048) v -= 4096; end
            3'd1: begin v = longint'({ins[31:25], ins[11:7]}); if (v >= 2048) v -= 4096; end
            3'd2: begin
                v = longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048
                  + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
                if (ins[31]) v -= 8192;
            end
            3'd3: begin
                v = longint'(ins[31]) * (1 << 20) + longint'(ins[19:12]) * 4096
                  + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
                if (ins[31]) v -= (1 << 21);
            end
            3'd4: begin v = longint'(ins[31:12]) * 4096; if (ins[31]) v -= (longint'(1) << 32); end
            3'd5: v = longint'(ins[19:15]);
            3'd6: v = (xlen == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
            default: v = 0;
        endcase
        if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds an entry on the input until the handshake completes; returns #1 after that edge.
    task automatic send(input logic [31:0] ins, input logic [2:0] src, input logic [31:0] tag);
        bit acc;
        acc = 0;
        in_valid = 1'b1;
        in_imm   = ins[31:7];
        in_src   = src;
        in_tag   = tag;
        for (int k = 0; k < 100 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready32 && !flush && !reset;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: tag %0d not accepted within 100 cycles", tag);
        end
        in_valid = 1'b0;
    endtask

    task automatic send_chk(input string nm, input logic [31:0] ins, input logic [2:0] src,
                            input logic [31:0] tag, input logic [63:0] e32, input logic [63:0] e64,
                            input logic eill);
        send(ins, src, tag);
        chk({nm, "_valid"}, 64'(out_valid32), 64'(1'b1));
        chk({nm, "_imm32"}, 64'(out_imm32), e32);
        chk({nm, "_imm64"}, out_imm64, e64);
        chk({nm, "_illegal"}, 64'(out_ill32), 64'(eill));
        chk({nm, "_tag"}, 64'(out_tag32), 64'(tag));
    endtask

    // Issue side of the scoreboard: record each accepted entry's expected result
    always @(negedge clk) begin
        logic [31:0] ins;
        ins = {in_imm, 7'b0};
        if (reset || flush) begin
            exp_q.delete();
        end else if (in_valid && in_ready32) begin
            exp_q.push_back('{ref_imm(ins, in_src, 32), ref_imm(ins, in_src, 64), in_tag, in_src == 3'd7});
        end
        if (in_valid && !in_ready32) seen_stall = 1;
    end

    // Monitor: compare every transferred output against the front of the queue
    always @(negedge clk) begin
        exp_t e;
        if (!reset && !flush) begin
            chk("valid_32_vs_64", 64'(out_valid64), 64'(out_valid32));
            chk("ready_32_vs_64", 64'(in_ready64), 64'(in_ready32));
            if (out_valid32 && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: tag %0d, expected no output", out_tag32);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_imm32", 64'(out_imm32), e.i32);
                    chk("sb_imm64", out_imm64, e.i64);
                    chk("sb_tag", 64'(out_tag32), 64'(e.tag));
                    chk("sb_illegal", 64'(out_ill32), 64'(e.ill));
                end
            end
        end
    end

    initial begin
        bit done;
        // reset state
        #12;
        chk("rst_out_valid", 64'(out_valid32), 64'(1'b0));
        chk("rst_in_ready", 64'(in_ready32), 64'(1'b1));
        chk("rst_out_imm64", out_imm64, 64'h0);
        chk("rst_out_tag", 64'(out_tag32), 64'h0);
        chk("rst_out_illegal", 64'(out_ill64), 64'h0);
        step();
        reset = 1'b0;
        step();

        // directed formats, one-cycle latency with out_ready high
        send_chk("i_neg1", 32'hFFF0_0093, 3'd0, 32'd100, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        send_chk("b_neg4", 32'hFE00_0EE3, 3'd2, 32'd101, 64'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        send_chk("u_pos", 32'h1234_50B7, 3'd4, 32'd102, 64'h1234_5000, 64'h0000_0000_1234_5000, 1'b0);
        send_chk("zimm", 32'h000F_8073, 3'd5, 32'd103, 64'h1F, 64'h1F, 1'b0);
        send_chk("rsvd", 32'hFFFF_FFFF, 3'd7, 32'd104, 64'h0, 64'h0, 1'b1);
        send_chk("u_neg", 32'h8000_00B7, 3'd4, 32'd105, 64'h8000_0000, 64'hFFFF_FFFF_8000_0000, 1'b0);
        send_chk("shamt", 32'h03F0_0013, 3'd6, 32'd106, 64'h1F, 64'h3F, 1'b0);
        step();

        // backpressure: out_ready low for three cycles while streaming tags 1..6
        seen_stall = 0;
        fork
            begin
                for (int t = 1; t <= 6; t++) send(32'h0010_0093 * t, 3'd0, 32'(t));
            end
            begin
                step();
                out_ready = 1'b0;
                repeat (3) step();
                out_ready = 1'b1;
            end
        join
        repeat (4) step();
        chk("bp_stall_seen", 64'(seen_stall), 64'(1'b1));
        chk("bp_drained", 64'(exp_q.size()), 64'h0);

        // flush with main and skid full and a new entry offered
        out_ready = 1'b0;
        send(32'h0020_0093, 3'd0, 32'd10);
        send(32'h0030_0093, 3'd0, 32'd11);
        chk("fl_in_ready_low", 64'(in_ready32), 64'(1'b0));
        in_valid = 1'b1;
        in_tag   = 32'd12;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_out_valid", 64'(out_valid32), 64'(1'b0));
        chk("fl_in_ready", 64'(in_ready32), 64'(1'b1));
        out_ready = 1'b1;
        repeat (4) step();

        // asynchronous reset between edges, mid-stream
        out_ready = 1'b0;
        send(32'hFFF0_0093, 3'd0, 32'd20);
        send(32'hFFF0_0093, 3'd0, 32'd21);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_out_valid", 64'(out_valid32), 64'(1'b0));
        chk("ar_out_imm32", 64'(out_imm32), 64'h0);
        chk("ar_out_imm64", out_imm64, 64'h0);
        chk("ar_in_ready", 64'(in_ready64), 64'(1'b1));
        step();
        reset = 1'b0;
        out_ready = 1'b1;
        step();
        send_chk("post_rst", 32'h0050_0013, 3'd0, 32'd22, 64'h5, 64'h5, 1'b0);
        step();

        // randomized stream against the reference model
        done = 0;
        fork
            begin
                for (int n = 0; n < 10000; n++) begin
                    if ($urandom_range(0, 3) == 0) step();
                    send($urandom, 3'($urandom_range(0, 7)), 32'(1000 + n));
                end
                done = 1;
            end
            begin
                while (!done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    step();
                end
                out_ready = 1'b1;
            end
        join
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) step();
        step();
        chk("final_drained", 64'(exp_q.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
